bcd_time_counter: RTL and testbench

Parametrised successor to the alarm-clock current-time counter. Keeps time-of-day as BCD digits (HH:MM, optionally :SS) advanced by a tick strobe through a configurable prescaler. Adds validated load, per-field set buttons, 12/24-hour display mode and a midnight rollover strobe. Feeds the display mux and alarm comparator.

---
 rtl/bcd_time_counter.sv | 102 ++++++++++
 tb/tb_bcd_time_counter.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/bcd_time_counter.sv
// bcd_time_counter: 24 h BCD time-of-day counter with tick prescaler, validated load,
// set-mode increments, 12/24 h display conversion and a midnight rollover strobe.
module bcd_time_counter #(
  parameter bit HAS_SECONDS = 1'b1,
  parameter int DIV = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       tick,
  input  logic       load_new_c,
  input  logic [3:0] new_ms_hr,
  input  logic [3:0] new_ls_hr,
  input  logic [3:0] new_ms_min,
  input  logic [3:0] new_ls_min,
  input  logic [3:0] new_ms_sec,
  input  logic [3:0] new_ls_sec,
  input  logic       inc_hr,
  input  logic       inc_min,
  input  logic       mode_12h,
  output logic [3:0] ms_hr,
  output logic [3:0] ls_hr,
  output logic [3:0] ms_min,
  output logic [3:0] ls_min,
  output logic [3:0] ms_sec,
  output logic [3:0] ls_sec,
  output logic       pm,
  output logic       day_rollover,
  output logic       load_err
);
  localparam int PW = DIV > 1 ? $clog2(DIV) : 1;
  localparam logic [PW-1:0] PMAX = PW'(DIV - 1);
  logic [3:0] h1_q, h0_q, m1_q, m0_q, s1_q, s0_q;
  logic [3:0] h1_d, h0_d, m1_d, m0_d, s1_d, s0_d;
  logic [PW-1:0] pre_q, pre_d;
  logic roll_q, roll_d, err_q, err_d;
  logic ld_ok, hr_max, min_max, sec_max, adv;
  logic [7:0] hr_nx, min_nx, sec_nx;
  logic [4:0] hb, dh;
  assign ld_ok = new_ms_hr <= 4'd2 && new_ls_hr <= 4'd9 && (new_ms_hr < 4'd2 || new_ls_hr <= 4'd3)
              && new_ms_min <= 4'd5 && new_ls_min <= 4'd9
              && (!HAS_SECONDS || (new_ms_sec <= 4'd5 && new_ls_sec <= 4'd9));
  assign hr_max  = h1_q == 4'd2 && h0_q == 4'd3;
  assign min_max = m1_q == 4'd5 && m0_q == 4'd9;
  assign sec_max = !HAS_SECONDS || (s1_q == 4'd5 && s0_q == 4'd9);
  assign adv     = tick && pre_q == PMAX;
  assign hr_nx  = hr_max ? 8'h00 : h0_q == 4'd9 ? {h1_q + 4'd1, 4'd0} : {h1_q, h0_q + 4'd1};
  assign min_nx = min_max ? 8'h00 : m0_q == 4'd9 ? {m1_q + 4'd1, 4'd0} : {m1_q, m0_q + 4'd1};
  assign sec_nx = (s1_q == 4'd5 && s0_q == 4'd9) ? 8'h00 : s0_q == 4'd9 ? {s1_q + 4'd1, 4'd0} : {s1_q, s0_q + 4'd1};
  always_comb begin
    {h1_d, h0_d, m1_d, m0_d, s1_d, s0_d} = {h1_q, h0_q, m1_q, m0_q, s1_q, s0_q};
    pre_d  = pre_q;
    roll_d = 1'b0;
    err_d  = 1'b0;
    if (load_new_c) begin
      if (ld_ok) begin
        {h1_d, h0_d, m1_d, m0_d} = {new_ms_hr, new_ls_hr, new_ms_min, new_ls_min};
        {s1_d, s0_d} = HAS_SECONDS ? {new_ms_sec, new_ls_sec} : 8'h00;
        pre_d = '0;
      end else err_d = 1'b1;
    end else if (inc_hr || inc_min) begin
      if (inc_hr) {h1_d, h0_d} = hr_nx;
      if (inc_min) begin
        {m1_d, m0_d} = min_nx;
        {s1_d, s0_d} = 8'h00;
        pre_d = '0;
      end
    end else if (tick) begin
      pre_d = adv ? '0 : pre_q + PW'(1);
      // ripple carry resolved combinationally so every digit moves on one edge
      if (adv) begin
        {s1_d, s0_d} = HAS_SECONDS ? sec_nx : 8'h00;
        if (sec_max) {m1_d, m0_d} = min_nx;
        if (sec_max && min_max) {h1_d, h0_d} = hr_nx;
        roll_d = sec_max && min_max && hr_max;
      end
    end
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      {h1_q, h0_q, m1_q, m0_q, s1_q, s0_q} <= '0;
      pre_q  <= '0;
      roll_q <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      {h1_q, h0_q, m1_q, m0_q, s1_q, s0_q} <= {h1_d, h0_d, m1_d, m0_d, s1_d, s0_d};
      pre_q  <= pre_d;
      roll_q <= roll_d;
      err_q  <= err_d;
    end
  end
  assign hb = 5'(h1_q) * 5'd10 + 5'(h0_q);
  assign dh = hb == 5'd0 ? 5'd12 : hb > 5'd12 ? hb - 5'd12 : hb;
  assign ms_hr  = mode_12h ? {3'd0, dh >= 5'd10} : h1_q;
  assign ls_hr  = mode_12h ? (dh >= 5'd10 ? 4'(dh - 5'd10) : dh[3:0]) : h0_q;
  assign ms_min = m1_q;
  assign ls_min = m0_q;
  assign ms_sec = HAS_SECONDS ? s1_q : 4'd0;
  assign ls_sec = HAS_SECONDS ? s0_q : 4'd0;
  assign pm = hb >= 5'd12;
  assign day_rollover = roll_q;
  assign load_err = err_q;
endmodule

// File: tb/tb_bcd_time_counter.sv
// tb_bcd_time_counter: three configurations driven in parallel against a seconds-of-day reference model.
module tb_bcd_time_counter;
  logic clk = 1'b0, reset = 1'b1, tick = 1'b0, load_new_c = 1'b0;
  logic inc_hr = 1'b0, inc_min = 1'b0, mode_12h = 1'b0;
  logic [3:0] nd[6];
  logic [3:0] mh[3], lh[3], mm[3], lm[3], ms[3], lsx[3];
  logic pm[3], dr[3], le[3];
  int tod[3], pre[3];
  bit eroll[3], eerr[3];
  int checks = 0, errors = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    bcd_time_counter #(.HAS_SECONDS(g != 2), .DIV(g == 1 ? 3 : 1)) u (
      .clk(clk), .reset(reset), .tick(tick), .load_new_c(load_new_c),
      .new_ms_hr(nd[0]), .new_ls_hr(nd[1]), .new_ms_min(nd[2]), .new_ls_min(nd[3]),
      .new_ms_sec(nd[4]), .new_ls_sec(nd[5]),
      .inc_hr(inc_hr), .inc_min(inc_min), .mode_12h(mode_12h),
      .ms_hr(mh[g]), .ls_hr(lh[g]), .ms_min(mm[g]), .ls_min(lm[g]),
      .ms_sec(ms[g]), .ls_sec(lsx[g]), .pm(pm[g]), .day_rollover(dr[g]), .load_err(le[g]));
  end

  function automatic int dv(int k); return k == 1 ? 3 : 1; endfunction
  function automatic bit hs(int k); return k != 2; endfunction

  function automatic bit valid(int k);
    int hr = nd[0] * 10 + nd[1], mi = nd[2] * 10 + nd[3], se = nd[4] * 10 + nd[5];
    if (nd[0] > 9 || nd[1] > 9 || nd[2] > 9 || nd[3] > 9) return 0;
    if (hr > 23 || mi > 59) return 0;
    if (hs(k) && (nd[4] > 9 || nd[5] > 9 || se > 59)) return 0;
    return 1;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 3; k++) begin
      tod[k] = 0; pre[k] = 0; eroll[k] = 0; eerr[k] = 0;
    end
  endtask

  task automatic model_step();
    for (int k = 0; k < 3; k++) begin
      int h = tod[k] / 3600, m = (tod[k] / 60) % 60, s = tod[k] % 60;
      eroll[k] = 0; eerr[k] = 0;
      if (reset) begin
        tod[k] = 0; pre[k] = 0;
      end else if (load_new_c) begin
        if (valid(k)) begin
          tod[k] = (nd[0] * 10 + nd[1]) * 3600 + (nd[2] * 10 + nd[3]) * 60 + (hs(k) ? nd[4] * 10 + nd[5] : 0);
          pre[k] = 0;
        end else eerr[k] = 1;
      end else if (inc_hr || inc_min) begin
        if (inc_hr) h = (h + 1) % 24;
        if (inc_min) begin m = (m + 1) % 60; s = 0; pre[k] = 0; end
        tod[k] = h * 3600 + m * 60 + s;
      end else if (tick) begin
        if (pre[k] == dv(k) - 1) begin
          pre[k] = 0;
          tod[k] = (tod[k] + (hs(k) ? 1 : 60)) % 86400;
          eroll[k] = tod[k] == 0;
        end else pre[k]++;
      end
    end
  endtask

  function automatic logic [26:0] expv(int k);
    int h = tod[k] / 3600, m = (tod[k] / 60) % 60, s = hs(k) ? tod[k] % 60 : 0;
    int d = !mode_12h ? h : h == 0 ? 12 : h > 12 ? h - 12 : h;
    return {4'(d / 10), 4'(d % 10), 4'(m / 10), 4'(m % 10), 4'(s / 10), 4'(s % 10), h >= 12, eroll[k], eerr[k]};
  endfunction

  function automatic logic [26:0] actv(int k);
    return {mh[k], lh[k], mm[k], lm[k], ms[k], lsx[k], pm[k], dr[k], le[k]};
  endfunction

  task automatic check_all(string nm);
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (actv(k) !== expv(k)) begin
        errors++;
        $display("FAIL %s dut%0d: got %h expected %h (hhmmss,pm,roll,err)", nm, k, actv(k), expv(k));
      end
    end
  endtask

  task automatic chk(string nm, int a, int e);
    checks++;
    if (a != e) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, a, e);
    end
  endtask

  task automatic cyc(string nm);
    model_step();
    @(posedge clk);
    #1;
    check_all(nm);
  endtask

  task automatic op(bit ld, bit tk, bit ih, bit im, string nm);
    load_new_c = ld; tick = tk; inc_hr = ih; inc_min = im;
    cyc(nm);
    load_new_c = 0; tick = 0; inc_hr = 0; inc_min = 0;
  endtask

  task automatic set_t(int h, int m, int s);
    nd[0] = 4'(h / 10); nd[1] = 4'(h % 10); nd[2] = 4'(m / 10);
    nd[3] = 4'(m % 10); nd[4] = 4'(s / 10); nd[5] = 4'(s % 10);
  endtask

  task automatic do_reset(string nm);
    #3 reset = 1;
    #1 model_reset();
    check_all({nm, "_async"});
    cyc({nm, "_hold"});
    reset = 0;
  endtask

  typedef struct { logic [3:0] d[6]; bit err_s; bit err_n; } ld_vec_t;
  typedef struct { int hh; int ems; int els; bit epm; } disp_vec_t;
  ld_vec_t lv[9];
  disp_vec_t dvv[9];

  initial begin
    lv[0] = '{'{2, 5, 1, 0, 0, 0}, 1, 1};
    lv[1] = '{'{1, 2, 6, 10, 0, 0}, 1, 1};
    lv[2] = '{'{1, 9, 4, 5, 3, 0}, 0, 0};
    lv[3] = '{'{2, 3, 5, 9, 6, 0}, 1, 0};
    lv[4] = '{'{2, 4, 0, 0, 0, 0}, 1, 1};
    lv[5] = '{'{0, 9, 5, 9, 5, 9}, 0, 0};
    lv[6] = '{'{1, 10, 0, 0, 0, 0}, 1, 1};
    lv[7] = '{'{0, 0, 0, 0, 0, 12}, 1, 0};
    lv[8] = '{'{2, 3, 5, 9, 5, 9}, 0, 0};
    dvv[0] = '{0, 1, 2, 0};  dvv[1] = '{1, 0, 1, 0};  dvv[2] = '{11, 1, 1, 0};
    dvv[3] = '{12, 1, 2, 1}; dvv[4] = '{13, 0, 1, 1}; dvv[5] = '{20, 0, 8, 1};
    dvv[6] = '{21, 0, 9, 1}; dvv[7] = '{22, 1, 0, 1}; dvv[8] = '{23, 1, 1, 1};
    set_t(0, 0, 0);
    model_reset();
    repeat (2) @(posedge clk);
    #1 check_all("reset");
    mode_12h = 1;
    #1 check_all("reset_12h");
    chk("reset_12h_hr", {mh[0], lh[0]}, 8'h12);
    mode_12h = 0;
    reset = 0;
    repeat (61) op(0, 1, 0, 0, "tick61");
    chk("t61_time", {mh[0], lh[0], mm[0], lm[0], ms[0], lsx[0]}, 24'h000101);
    mode_12h = 1;
    set_t(23, 59, 58);
    op(1, 0, 0, 0, "load_235958");
    op(0, 1, 0, 0, "tick_235959");
    op(0, 1, 0, 0, "tick_roll");
    chk("roll_pulse", dr[0], 1);
    chk("roll_12h", {mh[0], lh[0], mm[0], lm[0], ms[0], lsx[0], 3'b0, pm[0]}, 28'h1200000);
    op(0, 0, 0, 0, "after_roll");
    chk("roll_clear", dr[0], 0);
    mode_12h = 0;
    for (int i = 0; i < 9; i++) begin
      nd = lv[i].d;
      op(1, 0, 0, 0, "tbl_load");
      chk($sformatf("tbl_err_sec%0d", i), le[0], lv[i].err_s);
      chk($sformatf("tbl_err_nosec%0d", i), le[2], lv[i].err_n);
    end
    mode_12h = 1;
    for (int i = 0; i < 9; i++) begin
      set_t(dvv[i].hh, 34, 56);
      op(1, 0, 0, 0, "tbl_12h");
      chk($sformatf("tbl_12h_%0d", dvv[i].hh), {mh[0], lh[0], 3'b0, pm[0]},
          {4'(dvv[i].ems), 4'(dvv[i].els), 3'b0, dvv[i].epm});
    end
    mode_12h = 0;
    do_reset("rst_div3");
    repeat (5) op(0, 1, 0, 0, "div3_tick");
    chk("div3_ls_sec", lsx[1], 1);
    set_t(19, 45, 30);
    op(1, 1, 0, 0, "load_drop");
    repeat (2) op(0, 1, 0, 0, "div3_pre");
    chk("div3_held", lsx[1], 0);
    op(0, 1, 0, 0, "div3_adv");
    chk("div3_adv", lsx[1], 1);
    set_t(13, 59, 40);
    op(1, 0, 0, 0, "load_135940");
    op(0, 1, 0, 1, "inc_min");
    chk("inc_min_wrap", {mh[0], lh[0], mm[0], lm[0], ms[0], lsx[0]}, 24'h130000);
    mode_12h = 1;
    op(0, 1, 1, 1, "inc_both");
    chk("inc_both_12h", {mh[0], lh[0], mm[0], lm[0], 3'b0, pm[0]}, 20'h02011);
    mode_12h = 0;
    set_t(23, 10, 0);
    op(1, 0, 0, 0, "load_2310");
    op(0, 0, 1, 0, "inc_hr_wrap");
    chk("inc_hr_noroll", dr[0], 0);
    set_t(9, 59, 0);
    op(1, 0, 0, 0, "load_0959");
    op(0, 1, 0, 0, "nosec_tick");
    chk("nosec_time", {mh[2], lh[2], mm[2], lm[2], ms[2], lsx[2]}, 24'h100000);
    repeat (3) op(0, 1, 0, 0, "pre_reset");
    do_reset("rst_mid");
    chk("rst_mid_nosec", {mh[2], lh[2], mm[2], lm[2]}, 0);
    repeat (1500) begin
      int r = $urandom_range(0, 15);
      bit ld = r == 0 || r == 5;
      mode_12h = 1'($urandom_range(0, 1));
      if (ld) begin
        int c = $urandom_range(0, 3);
        if (c == 0) for (int j = 0; j < 6; j++) nd[j] = 4'($urandom_range(0, 15));
        else if (c == 1) set_t(23, 59, $urandom_range(45, 59));
        else set_t($urandom_range(0, 23), $urandom_range(0, 59), $urandom_range(0, 59));
      end
      if ($urandom_range(0, 299) == 0) do_reset("rand_rst");
      op(ld, 1'($urandom_range(0, 3) != 0), r == 1 || r == 3, r == 2 || r == 3, "rand");
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
